// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, masters the imem req/ack port and buffers returned words for decode.
// Optional macro FETCH_BYPASS_EN forwards a returning word straight to decode when the FIFO is empty.
module instr_fetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [31:0]              if_instr,
   output logic [ADDR_W-1:0]        if_pc4,
   output logic [$clog2(DEPTH):0]   fq_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, drop_addr_q, pc4_w;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [31:0]       instr_mem [DEPTH];
   logic [ADDR_W-1:0] pc4_mem   [DEPTH];
   logic              handshake, good_hs, push, pop, fifo_empty;

   // In RUN nothing is outstanding, so FIFO occupancy alone gates a new request.
   always_comb begin
      fifo_empty = (count_q == '0);
      imem_req   = rst && ((state_q != S_RUN) || (count_q < FULL));
      imem_addr  = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
      handshake  = imem_req && imem_ack;
      good_hs    = handshake && (state_q != S_DROP) && !redirect_valid;
      pc4_w      = fetch_pc_q + ADDR_W'(4);
      pop        = !fifo_empty && if_ready && !redirect_valid;
`ifdef FETCH_BYPASS_EN
      // Forwarding only when the FIFO is empty keeps the FIFO head ahead of the live word.
      if_valid   = !fifo_empty || good_hs;
      if_instr   = fifo_empty ? imem_rdata : instr_mem[rd_ptr_q];
      if_pc4     = fifo_empty ? pc4_w      : pc4_mem[rd_ptr_q];
      push       = good_hs && !(fifo_empty && if_ready);
`else
      if_valid   = !fifo_empty;
      if_instr   = instr_mem[rd_ptr_q];
      if_pc4     = pc4_mem[rd_ptr_q];
      push       = good_hs;
`endif
      fq_count   = count_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (imem_req && !imem_ack) state_d = S_WAIT;
         S_WAIT:  if (imem_ack) state_d = S_RUN;
         S_DROP:  if (imem_ack) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
      // A redirected request that is still unanswered must be held to completion and discarded.
      if (redirect_valid && imem_req && !imem_ack)
         state_d = S_DROP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_RUN;
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q <= state_d;
         if (redirect_valid)
            fetch_pc_q <= redirect_pc;
         else if (good_hs)
            fetch_pc_q <= pc4_w;
         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Storage and the held wrong-path address are data only; they are qualified by control state.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc4_mem[wr_ptr_q]   <= pc4_w;
      end
      if ((state_q != S_DROP) && (state_d == S_DROP))
         drop_addr_q <= imem_addr;
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed and randomized bench for instr_fetch_queue with a latency-programmable imem responder.
module tb_instr_fetch_queue;

   localparam logic [31:0] KEY = 32'h5A5A_0000;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic        clk, rst;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc4;
   logic [2:0]  fq_count;

   int checks = 0;
   int errors = 0;
   int ack_lat = 0;
   int wait_cnt;

   instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc4(if_pc4),
      .fq_count(fq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // imem responder: acks once the request has been waiting ack_lat cycles
   always_comb begin
      imem_ack   = imem_req && (wait_cnt >= ack_lat);
      imem_rdata = imem_addr ^ KEY;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) wait_cnt <= 0;
      else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task do_reset;
      rst = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task test_reset;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", if_valid); end
      checks++; if (fq_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fq_count); end
   endtask

   task test_stream;
      if_ready = 1'b1; ack_lat = 0;
      do_reset;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin
            errors++; $display("FAIL stream_addr k=%0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4*k));
         end
         checks++;
         if (if_valid !== (k >= LAT)) begin
            errors++; $display("FAIL stream_valid k=%0d got=%b want=%b", k, if_valid, (k >= LAT));
         end
         if (k >= LAT) begin
            checks++;
            if (if_pc4 !== 32'(4*(k-LAT)+4) || if_instr !== (32'(4*(k-LAT)) ^ KEY)) begin
               errors++; $display("FAIL stream_data k=%0d got pc4=%h instr=%h want pc4=%h instr=%h",
                                  k, if_pc4, if_instr, 32'(4*(k-LAT)+4), 32'(4*(k-LAT)) ^ KEY);
            end
         end
         @(negedge clk);
      end
   endtask

   task test_stall;
      if_ready = 1'b0; ack_lat = 0;
      do_reset;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4*k) || fq_count !== 3'(k)) begin
            errors++; $display("FAIL stall_fill k=%0d got req=%b addr=%h cnt=%0d want req=1 addr=%h cnt=%0d",
                               k, imem_req, imem_addr, fq_count, 32'(4*k), k);
         end
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (fq_count !== 3'd4 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_full got cnt=%0d req=%b want cnt=4 req=0", fq_count, imem_req);
         end
         @(negedge clk);
      end
      if_ready = 1'b1;
      for (int d = 0; d < 4; d++) begin
         #1;
         checks++;
         if (if_valid !== 1'b1 || if_pc4 !== 32'(4*d+4) || if_instr !== (32'(4*d) ^ KEY)) begin
            errors++; $display("FAIL stall_drain d=%0d got v=%b pc4=%h want v=1 pc4=%h", d, if_valid, if_pc4, 32'(4*d+4));
         end
         if (d == 1) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
               errors++; $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=10", imem_req, imem_addr);
            end
         end
         @(negedge clk);
      end
   endtask

   task test_redirect_drop;
      bit found;
      if_ready = 1'b1; ack_lat = 0;
      do_reset;
      for (int k = 0; k < 8; k++) @(negedge clk);
      ack_lat = 3;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
         errors++; $display("FAIL drop_setup got req=%b addr=%h want req=1 addr=20", imem_req, imem_addr);
      end
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            errors++; $display("FAIL drop_hold c=%0d got req=%b addr=%h want req=1 addr=20", c, imem_req, imem_addr);
         end
         if (c > 0) begin
            checks++;
            if (if_valid !== 1'b0) begin
               errors++; $display("FAIL drop_leak c=%0d got valid=%b instr=%h want valid=0", c, if_valid, if_instr);
            end
         end
         @(negedge clk);
         redirect_valid = 1'b0;
      end
      ack_lat = 0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++; $display("FAIL drop_newaddr got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr);
      end
      found = 1'b0;
      for (int i = 0; i < 3 && !found; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         if (if_valid) begin
            found = 1'b1;
            checks++;
            if (if_pc4 !== 32'h104 || if_instr !== (32'h100 ^ KEY)) begin
               errors++; $display("FAIL drop_first got pc4=%h instr=%h want pc4=104 instr=%h", if_pc4, if_instr, 32'h100 ^ KEY);
            end
         end
      end
      if (!found) begin
         checks++; errors++; $display("FAIL drop_timeout got valid=0 want valid=1 within 3 cycles");
      end
      @(negedge clk);
   endtask

   task test_redirect_ack;
      if_ready = 1'b0; ack_lat = 0;
      do_reset;
      @(negedge clk);
      @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      #1;
      checks++;
      if (fq_count !== 3'd2 || imem_ack !== 1'b1 || imem_addr !== 32'h8) begin
         errors++; $display("FAIL rack_setup got cnt=%0d ack=%b addr=%h want cnt=2 ack=1 addr=8", fq_count, imem_ack, imem_addr);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (fq_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         errors++; $display("FAIL rack_flush got cnt=%0d req=%b addr=%h want cnt=0 req=1 addr=200", fq_count, imem_req, imem_addr);
      end
      @(negedge clk);
      if_ready = 1'b1;
      #1;
      checks++;
      if (if_valid !== 1'b1 || if_pc4 !== 32'h204 || fq_count !== 3'd1) begin
         errors++; $display("FAIL rack_next got v=%b pc4=%h cnt=%0d want v=1 pc4=204 cnt=1", if_valid, if_pc4, fq_count);
      end
      @(negedge clk);
   endtask

   task test_mid_reset;
      if_ready = 1'b0; ack_lat = 0;
      do_reset;
      for (int k = 0; k < 3; k++) @(negedge clk);
      ack_lat = 5;
      @(negedge clk);
      #1;
      checks++;
      if (fq_count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
         errors++; $display("FAIL mrst_setup got cnt=%0d req=%b addr=%h want cnt=3 req=1 addr=c", fq_count, imem_req, imem_addr);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || fq_count !== 3'd0) begin
         errors++; $display("FAIL mrst_async got req=%b addr=%h v=%b cnt=%0d want req=0 addr=0 v=0 cnt=0",
                            imem_req, imem_addr, if_valid, fq_count);
      end
      @(negedge clk);
      rst = 1'b1; ack_lat = 0; if_ready = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL mrst_restart got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if (imem_addr !== 32'h4) begin
         errors++; $display("FAIL mrst_second got addr=%h want addr=4", imem_addr);
      end
      @(negedge clk);
   endtask

   task test_random;
      logic [31:0] exp_pc, prev_addr;
      logic        prev_req, prev_ack;
      int          delivered;
      if_ready = 1'b1; ack_lat = 0;
      do_reset;
      exp_pc = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0; delivered = 0;
      for (int c = 0; c < 10000; c++) begin
         if_ready = ($urandom_range(0, 3) != 0);
         if (wait_cnt == 0) ack_lat = $urandom_range(0, 5);
         redirect_valid = ($urandom_range(0, 39) == 0);
         redirect_pc = 32'($urandom_range(0, 1023)) << 2;
         #1;
         if (prev_req && !prev_ack) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               errors++; $display("FAIL rnd_hold c=%0d got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, prev_addr);
            end
         end
         checks++;
         if (fq_count > 3'd4) begin
            errors++; $display("FAIL rnd_count c=%0d got cnt=%0d want <=4", c, fq_count);
         end
         if (redirect_valid) begin
            exp_pc = redirect_pc;
         end else if (if_valid && if_ready) begin
            checks++;
            if (if_pc4 !== exp_pc + 32'd4 || if_instr !== (exp_pc ^ KEY)) begin
               errors++; $display("FAIL rnd_order c=%0d got pc4=%h instr=%h want pc4=%h instr=%h",
                                  c, if_pc4, if_instr, exp_pc + 32'd4, exp_pc ^ KEY);
            end
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
         @(negedge clk);
      end
      redirect_valid = 1'b0;
      checks++;
      if (delivered < 500) begin
         errors++; $display("FAIL rnd_progress got delivered=%0d want >=500", delivered);
      end
   endtask

   initial begin
      if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      test_reset;
      test_stream;
      test_stall;
      test_redirect_drop;
      test_redirect_ack;
      test_mid_reset;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
